// File: rtl/psum_rmw_ctrl_if.sv
// Bundle of the psum accumulator's three bus groups: contribution, downstream psum and RF ports.
// The slave modport is the accumulator's view; master is the surrounding environment.
interface psum_rmw_ctrl_if #(
    parameter int WORDWD = 12,
    parameter int DWD    = 16,
    parameter int AWD    = $clog2(WORDWD),
    parameter int SIZE   = 1
);
    logic                       i_valid;
    logic                       o_ready;
    logic [AWD-1:0]             i_addr;
    logic [SIZE-1:0][DWD-1:0]   i_data;
    logic                       i_first;
    logic                       i_last;

    logic                       o_valid;
    logic                       i_ready;
    logic [AWD-1:0]             o_addr;
    logic [SIZE-1:0][DWD-1:0]   o_psum;

    logic                       o_rf_read;
    logic [AWD-1:0]             o_rf_raddr;
    logic [SIZE-1:0][DWD-1:0]   i_rf_rdata;
    logic                       o_rf_write;
    logic [AWD-1:0]             o_rf_waddr;
    logic [SIZE-1:0][DWD-1:0]   o_rf_wdata;

    modport slave (
        input  i_valid, i_addr, i_data, i_first, i_last, i_ready, i_rf_rdata,
        output o_ready, o_valid, o_addr, o_psum,
        output o_rf_read, o_rf_raddr, o_rf_write, o_rf_waddr, o_rf_wdata
    );

    modport master (
        output i_valid, i_addr, i_data, i_first, i_last, i_ready, i_rf_rdata,
        input  o_ready, o_valid, o_addr, o_psum,
        input  o_rf_read, o_rf_raddr, o_rf_write, o_rf_waddr, o_rf_wdata
    );
endinterface

// File: rtl/psum_rmw_ctrl.sv
// Read-modify-write psum accumulator in front of a two-port RF: S0 read issue, S1 add, S2 write.
// Same-address hazards against ops still in S1/S2 are resolved by forwarding instead of reading.
module psum_rmw_lane #(
    parameter int DWD = 16
) (
    input  logic [DWD-1:0] i_opnd,
    input  logic [DWD-1:0] i_data,
    input  logic           i_first,
    output logic [DWD-1:0] o_sum
);
    logic [DWD:0] wide;

    always_comb begin
        wide = {i_opnd[DWD-1], i_opnd} + {i_data[DWD-1], i_data};
        if (i_first) begin
            o_sum = i_data;
        end else if (wide[DWD] != wide[DWD-1]) begin
            // the two top bits disagree only on overflow; wide[DWD] is the true sign
            o_sum = wide[DWD] ? {1'b1, {(DWD-1){1'b0}}} : {1'b0, {(DWD-1){1'b1}}};
        end else begin
            o_sum = wide[DWD-1:0];
        end
    end
endmodule

module psum_rmw_ctrl #(
    parameter int WORDWD = 12,
    parameter int DWD    = 16,
    parameter int AWD    = $clog2(WORDWD),
    parameter int SIZE   = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    psum_rmw_ctrl_if.slave bus
);
    typedef logic [SIZE-1:0][DWD-1:0] vec_t;
    typedef enum logic [1:0] {FWD_NONE = 2'd0, FWD_S1 = 2'd1, FWD_S2 = 2'd2} fwd_sel_e;

    typedef struct packed {
        logic [AWD-1:0] addr;
        vec_t           data;
        logic           first;
        logic           last;
        fwd_sel_e       sel;
    } s1_t;

    typedef struct packed {
        logic [AWD-1:0] addr;
        vec_t           sum;
        logic           last;
    } s2_t;

    logic [2:1] vld_pipe_q, vld_pipe_d;
    s1_t        s1_q, s1_d;
    s2_t        s2_q, s2_d;
    vec_t       fwd_q, fwd_d;
    logic       written_q, written_d;

    logic       stall, accept, hit_s1, hit_s2;
    vec_t       opnd, sum;

    always_comb begin
        stall  = vld_pipe_q[2] && s2_q.last && !bus.i_ready;
        accept = bus.i_valid && !stall;
        hit_s1 = vld_pipe_q[1] && (s1_q.addr == bus.i_addr);
        hit_s2 = vld_pipe_q[2] && (s2_q.addr == bus.i_addr);
        // S1-hit means the older op now sits in S2; S2-hit means it retired into fwd_q
        case (s1_q.sel)
            FWD_S1:  opnd = s2_q.sum;
            FWD_S2:  opnd = fwd_q;
            default: opnd = bus.i_rf_rdata;
        endcase
    end

    for (genvar l = 0; l < SIZE; l++) begin : g_lane
        psum_rmw_lane #(.DWD(DWD)) u_lane (
            .i_opnd  (opnd[l]),
            .i_data  (s1_q.data[l]),
            .i_first (s1_q.first),
            .o_sum   (sum[l])
        );
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        fwd_d      = fwd_q;
        // a stalled S2 op has already written in its first cycle
        written_d  = stall;
        if (!stall) begin
            vld_pipe_d = {vld_pipe_q[1], accept};
            if (vld_pipe_q[1]) begin
                s2_d.addr = s1_q.addr;
                s2_d.sum  = sum;
                s2_d.last = s1_q.last;
            end
            if (accept) begin
                s1_d.addr  = bus.i_addr;
                s1_d.data  = bus.i_data;
                s1_d.first = bus.i_first;
                s1_d.last  = bus.i_last;
                if (bus.i_first)  s1_d.sel = FWD_NONE;
                else if (hit_s1)  s1_d.sel = FWD_S1;
                else if (hit_s2)  s1_d.sel = FWD_S2;
                else              s1_d.sel = FWD_NONE;
                fwd_d = s2_q.sum;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            fwd_q      <= '0;
            written_q  <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            fwd_q      <= fwd_d;
            written_q  <= written_d;
        end
    end

    assign bus.o_ready    = !stall;
    assign bus.o_rf_read  = accept && !bus.i_first && !hit_s1 && !hit_s2;
    assign bus.o_rf_raddr = bus.i_addr;
    assign bus.o_rf_write = vld_pipe_q[2] && !written_q;
    assign bus.o_rf_waddr = s2_q.addr;
    assign bus.o_rf_wdata = s2_q.sum;
    assign bus.o_valid    = vld_pipe_q[2] && s2_q.last;
    assign bus.o_addr     = s2_q.addr;
    assign bus.o_psum     = s2_q.sum;
endmodule

// File: tb/tb_psum_rmw_ctrl.sv
// Bench for psum_rmw_ctrl: RF model, directed hazard/saturation/stall/reset cases and a random run,
// all scored against an in-order psum reference array.
module tb_psum_rmw_ctrl;
    localparam int WORDWD = 12;
    localparam int DWD    = 16;
    localparam int SIZE   = 2;
    localparam int AWD    = $clog2(WORDWD);
    localparam int MAXV   = 2 ** (DWD - 1) - 1;
    localparam int MINV   = -(2 ** (DWD - 1));

    typedef logic [SIZE-1:0][DWD-1:0] vec_t;
    typedef struct packed { logic [AWD-1:0] addr; vec_t val; } ent_t;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    psum_rmw_ctrl_if #(.WORDWD(WORDWD), .DWD(DWD), .AWD(AWD), .SIZE(SIZE)) bus ();

    psum_rmw_ctrl #(.WORDWD(WORDWD), .DWD(DWD), .AWD(AWD), .SIZE(SIZE)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    // RF_2P model: registered read that holds when idle, garbage on same-address collision
    vec_t rf [WORDWD] = '{default: '0};
    vec_t rdata_q = '0;
    assign bus.i_rf_rdata = rdata_q;
    always @(posedge i_clk) begin
        if (bus.o_rf_read)
            rdata_q <= (bus.o_rf_write && bus.o_rf_raddr == bus.o_rf_waddr) ? {(SIZE*DWD){1'b1}}
                                                                            : rf[bus.o_rf_raddr];
        if (bus.o_rf_write) rf[bus.o_rf_waddr] <= bus.o_rf_wdata;
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_wr    = 0;
    int   n_rd    = 0;
    bit   rand_rdy;
    bit   acc_rd;
    logic [AWD-1:0] acc_raddr;

    vec_t ref_ps [WORDWD] = '{default: '0};
    ent_t wr_q [$];
    ent_t out_q [$];
    ent_t e;
    bit   stalled_prev = 1'b0;
    logic [AWD-1:0] prev_addr;
    vec_t prev_psum;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic vec_t acc(input vec_t old, input vec_t d, input bit first);
        vec_t r;
        int   s;
        for (int l = 0; l < SIZE; l++) begin
            s = first ? int'($signed(d[l])) : int'($signed(old[l])) + int'($signed(d[l]));
            if (s > MAXV) s = MAXV;
            if (s < MINV) s = MINV;
            r[l] = s[DWD-1:0];
        end
        return r;
    endfunction

    function automatic vec_t mk(input int l0, input int l1);
        vec_t r;
        r[0] = 16'(l0);
        r[1] = 16'(l1);
        return r;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t r;
        for (int l = 0; l < SIZE; l++)
            r[l] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 64)) - 16'd32;
        return r;
    endfunction

    always @(posedge i_rst) begin
        wr_q.delete();
        out_q.delete();
        ref_ps = rf;
        stalled_prev = 1'b0;
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (bus.o_rf_read && bus.o_rf_write)
                chk("rf_collision", 64'(bus.o_rf_raddr == bus.o_rf_waddr), 64'(0));
            if (bus.o_rf_read) n_rd++;
            if (bus.o_rf_write) begin
                n_wr++;
                if (wr_q.size() == 0) chk("spurious_write", 64'(bus.o_rf_waddr), 64'hDEAD);
                else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", 64'(bus.o_rf_waddr), 64'(e.addr));
                    chk("wr_data", 64'(bus.o_rf_wdata), 64'(e.val));
                end
            end
            if (stalled_prev)
                chk("stall_hold", 64'({bus.o_valid, bus.o_addr, bus.o_psum}), 64'({1'b1, prev_addr, prev_psum}));
            if (bus.o_valid && bus.i_ready) begin
                if (out_q.size() == 0) chk("spurious_out", 64'(bus.o_psum), 64'hDEAD);
                else begin
                    e = out_q.pop_front();
                    chk("out_addr", 64'(bus.o_addr), 64'(e.addr));
                    chk("out_psum", 64'(bus.o_psum), 64'(e.val));
                end
            end
            stalled_prev = bus.o_valid && !bus.i_ready;
            prev_addr    = bus.o_addr;
            prev_psum    = bus.o_psum;
            if (bus.i_valid && bus.o_ready) begin
                e.addr = bus.i_addr;
                e.val  = acc(ref_ps[bus.i_addr], bus.i_data, bus.i_first);
                ref_ps[bus.i_addr] = e.val;
                wr_q.push_back(e);
                if (bus.i_last) out_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #2;
        if (rand_rdy) bus.i_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic issue(input int a, input vec_t d, input bit f, input bit l);
        bit got;
        got = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_addr  = AWD'(a);
        bus.i_data  = d;
        bus.i_first = f;
        bus.i_last  = l;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge i_clk);
            if (bus.o_ready) begin
                got       = 1'b1;
                acc_rd    = bus.o_rf_read;
                acc_raddr = bus.o_rf_raddr;
            end
            step();
        end
        if (!got) chk("accept_timeout", 64'(0), 64'(1));
        bus.i_valid = 1'b0;
    endtask

    task automatic out_chk(input string tag, input vec_t exp);
        step();
        @(negedge i_clk);
        chk(tag, 64'({bus.o_valid, bus.o_psum}), 64'({1'b1, exp}));
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   w0, r0, a;
        vec_t keep;
        bit   f, l;
        i_rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_addr = '0; bus.i_data = '0;
        bus.i_first = 1'b0; bus.i_last = 1'b0; bus.i_ready = 1'b1;
        rand_rdy = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.o_valid), 64'(0));
        chk("rst_rf_write", 64'(bus.o_rf_write), 64'(0));
        chk("rst_rf_read", 64'(bus.o_rf_read), 64'(0));
        chk("rst_outs", 64'({bus.o_addr, bus.o_psum}), 64'(0));
        chk("rst_wr_bus", 64'({bus.o_rf_waddr, bus.o_rf_wdata}), 64'(0));
        repeat (2) step();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_ready", 64'(bus.o_ready), 64'(1));
        step();

        // first then accumulate, spaced out
        issue(3, mk(5, 5), 1'b1, 1'b0);
        repeat (4) step();
        issue(3, mk(7, 7), 1'b0, 1'b1);
        chk("spaced_rd", 64'({acc_rd, acc_raddr}), 64'({1'b1, 4'd3}));
        out_chk("spaced_psum", mk(12, 12));
        repeat (3) step();

        // back-to-back same address
        r0 = n_rd;
        issue(2, mk(1, 1), 1'b1, 1'b0);
        issue(2, mk(2, 2), 1'b0, 1'b0);
        issue(2, mk(3, 3), 1'b0, 1'b1);
        chk("b2b_no_read", 64'(n_rd - r0), 64'(0));
        out_chk("b2b_psum", mk(6, 6));
        repeat (3) step();

        // one-cycle gap, then interleaved addresses
        issue(5, mk(10, 10), 1'b1, 1'b0);
        step();
        issue(5, mk(4, 4), 1'b0, 1'b1);
        chk("gap_no_read", 64'(acc_rd), 64'(0));
        out_chk("gap_psum", mk(14, 14));
        repeat (3) step();
        issue(1, mk(1, 1), 1'b1, 1'b0);
        issue(5, mk(0, 0), 1'b0, 1'b0);
        issue(1, mk(1, 1), 1'b0, 1'b1);
        out_chk("ilv_psum", mk(2, 2));
        repeat (3) step();

        // saturation, lanes independently in opposite directions
        issue(8, mk(16'h7FF0, 16'h8000), 1'b1, 1'b0);
        repeat (3) step();
        issue(8, mk(16'h0020, 16'hFFFF), 1'b0, 1'b1);
        out_chk("sat_psum", mk(16'h7FFF, 16'h8000));
        repeat (3) step();

        // backpressure with a trailing same-address op waiting upstream
        w0 = n_wr;
        bus.i_ready = 1'b0;
        issue(4, mk(100, -100), 1'b1, 1'b1);
        step();
        bus.i_valid = 1'b1; bus.i_addr = 4'd4; bus.i_data = mk(1, 1);
        bus.i_first = 1'b0; bus.i_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("bp_valid", 64'(bus.o_valid), 64'(1));
            chk("bp_ready", 64'(bus.o_ready), 64'(0));
            step();
        end
        bus.i_ready = 1'b1;
        issue(4, mk(1, 1), 1'b0, 1'b1);
        out_chk("bp_trail_psum", mk(101, -99));
        repeat (3) step();
        chk("bp_write_once", 64'(n_wr - w0), 64'(2));

        // async reset with ops in S1 and S2
        keep = rf[6];
        issue(6, mk(9, 9), 1'b1, 1'b1);
        issue(7, mk(2, 2), 1'b1, 1'b0);
        #1;
        i_rst = 1'b1;
        #1;
        chk("mid_rst_outs", 64'({bus.o_valid, bus.o_rf_write, bus.o_psum}), 64'(0));
        chk("mid_rst_wdata", 64'(bus.o_rf_wdata), 64'(0));
        repeat (2) step();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_ready", 64'({bus.o_ready, bus.o_rf_write}), 64'(2'b10));
        repeat (4) step();
        chk("rst_no_write", 64'(rf[6]), 64'(keep));

        // randomized run against the reference array
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WORDWD - 1) : $urandom_range(0, 3);
            f = ($urandom_range(0, 4) == 0);
            l = ($urandom_range(0, 4) < 2);
            issue(a, rnd_vec(), f, l);
            repeat ($urandom_range(0, 2)) step();
        end
        rand_rdy = 1'b0;
        bus.i_ready = 1'b1;
        repeat (10) step();
        chk("wr_q_drained", 64'(wr_q.size()), 64'(0));
        chk("out_q_drained", 64'(out_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/psum_rmw_ctrl.md
Name: psum_rmw_ctrl

Overview:
- Read-modify-write partial-sum accumulator that sits directly in front of an RF_2P register-file instance.
- Drives the RF read port to fetch a stored psum and consumes the RF read data. Adds an incoming contribution, then drives the RF write port with the result.
- Resolves the RF's same-address read/write collision, which returns X, by forwarding. Streams final psums downstream on i_last.

Parameters:
- WORDWD, 12, number of RF words (psum entries).
- DWD, 16, psum width in bits; signed two's complement.
- AWD, $clog2(WORDWD), address width.
- SIZE, 1, number of parallel lanes. All lanes share one address.

Ports:
- i_clk  in  1  clock; all state on posedge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  contribution valid.
- o_ready  out  1  contribution accepted when i_valid && o_ready.
- i_addr  in  AWD  psum entry address.
- i_data  in  DWD x SIZE  signed contribution per lane.
- i_first  in  1  overwrite: psum = i_data; RF is not read.
- i_last  in  1  also emit the resulting psum downstream.
- o_valid  out  1  final psum valid.
- i_ready  in  1  downstream ready.
- o_addr  out  AWD  address of the emitted psum.
- o_psum  out  DWD x SIZE  emitted psum.
- o_rf_read  out  1  RF read enable.
- o_rf_raddr  out  AWD  RF read address.
- i_rf_rdata  in  DWD x SIZE  RF read data, valid the cycle after o_rf_read.
- o_rf_write  out  1  RF write enable.
- o_rf_waddr  out  AWD  RF write address.
- o_rf_wdata  out  DWD x SIZE  RF write data.

Behaviour:
- Reset: all stage valids cleared. o_valid=0, o_rf_read=0, o_rf_write=0. o_addr, o_psum, o_rf_waddr, o_rf_wdata are 0. o_ready=1 after reset.
- Three-stage pipeline:
  - S0 (accept cycle T): o_rf_read and o_rf_raddr are combinational from i_addr.
  - S1 (T+1): lane sums are computed and registered.
  - S2 (T+2): o_rf_write=1, with o_rf_waddr and o_rf_wdata taken from the S2 register.
- Read issue: o_rf_read = i_valid && o_ready && !i_first && no forward hit.
- Forward hit is decided at accept by comparing i_addr against S1 and S2. When both match, S1 has priority.
  - Hit on S1 (older op one cycle ahead): in S1, the operand is taken from the S2 register value (the older op's result).
  - Hit on S2 (older op being written in cycle T): the S2 wdata is captured into a forward register at the end of T; in S1 that register is the operand.
  - No hit: the operand is i_rf_rdata.
- Invariant: o_rf_read && o_rf_write && (o_rf_raddr == o_rf_waddr) is never true.
- Arithmetic, per lane:
  - sum = sat(operand + i_data), computed at DWD+1 bits and then saturated.
  - Saturation limits are 2^(DWD-1)-1 and -2^(DWD-1).
  - i_first: sum = i_data; no add, no forwarding used.
- Output on i_last: while the op is in S2, o_valid=1 and o_psum/o_addr equal the S2 values.
- Stall: stall = S2 valid && S2 last && !i_ready.
  - o_ready = !stall.
  - On stall, S1 and S2 hold their contents and no read is issued, so the RF output holds and the S1 operand stays valid.
  - o_rf_write pulses exactly once per op, on its first S2 cycle. A written flag suppresses repeats during a stall.
  - o_psum and o_addr stay stable while stalled.
- Non-last ops never stall. S2 retires in one cycle.
- Bubbles: a stage with no valid op does not update the forward compare. Its valid bit gates all matches.
- Address wrap: addresses ≥ WORDWD are outside the contract and are not checked.
- Async reset mid-operation drops all in-flight ops. The RF contents are left as last written. No partial write occurs after reset asserts.

Test Plan:
- First then accumulate, spaced out:
  - Stimulus: addr 3, first, data 5; 4 idle cycles; addr 3, data 7, last.
  - Response: second op reads RF addr 3. o_psum=12, o_addr=3. RF write addr 3 = 12 two cycles after accept.
- Back-to-back same address:
  - Stimulus: addr 2 ops on consecutive cycles: first 1, +2, +3 last.
  - Response: o_rf_read never asserted. RF writes 1, 3, 6 on consecutive cycles. o_psum=6.
- One-cycle gap:
  - Stimulus: addr 5, first, 10 at T; addr 5, +4, last at T+2.
  - Response: read suppressed at T+2 (collision avoided). o_psum=14.
  - Interleaved check: addr 1 first 1 at T, addr 5 +0 at T+1, addr 1 +1 last at T+2 gives o_psum=2 with no collision.
- Saturation, DWD=16:
  - Stored 0x7FF0 + 0x0020 → 0x7FFF.
  - Stored 0x8000 + 0xFFFF → 0x8000.
  - SIZE=2: lanes saturate independently.
- Backpressure:
  - Stimulus: last op with i_ready=0 for 3 cycles.
  - Response: o_valid held 4 cycles with o_psum constant. o_rf_write pulses once. o_ready=0 during the stall. A trailing same-address op queued upstream then forwards correctly.
- Reset mid-op:
  - Stimulus: assert i_rst asynchronously with ops in S1 and S2.
  - Response: outputs go to 0 immediately with no clock. No o_rf_write after reset. o_ready=1 after release.
